// File: rtl/cpu_datapath_pkg.sv
// Shared definitions for the single-bus CPU datapath: ALU opcodes, bus-source
// encoder bit positions and memory geometry.
package cpu_datapath_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned NUM_REGS  = 16;
  localparam int unsigned MEM_DEPTH = 512;
  localparam int unsigned MEM_AW    = $clog2(MEM_DEPTH);

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_AND  = 5'b00101,
    OP_OR   = 5'b00110,
    OP_SHR  = 5'b00111,
    OP_SHRA = 5'b01000,
    OP_SHL  = 5'b01001,
    OP_ROR  = 5'b01010,
    OP_ROL  = 5'b01011,
    OP_MUL  = 5'b01111,
    OP_DIV  = 5'b10000,
    OP_NEG  = 5'b10001,
    OP_NOT  = 5'b10010
  } alu_op_e;

  // Bit positions of the non-register sources in encoder_input (R0-R15 are bits 0-15).
  localparam int unsigned ENC_HI     = 16;
  localparam int unsigned ENC_LO     = 17;
  localparam int unsigned ENC_ZHIGH  = 18;
  localparam int unsigned ENC_ZLOW   = 19;
  localparam int unsigned ENC_PC     = 20;
  localparam int unsigned ENC_MDR    = 21;
  localparam int unsigned ENC_INPORT = 22;
  localparam int unsigned ENC_C      = 23;

  function automatic logic [DATA_W-1:0] sext19(input logic [18:0] v);
    return {{(DATA_W-19){v[18]}}, v};
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: A comes from Y, B from the bus; 64-bit result where
// 32-bit operations leave the upper half zero.
module cpu_alu
  import cpu_datapath_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  op_i,
  output logic [63:0] result_o
);

  logic [4:0]  sh;
  logic [63:0] dbl_r;
  logic [63:0] dbl_l;
  logic [63:0] prod;
  logic [31:0] sra;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        unused_bits;

  assign sh    = b_i[4:0];
  // Rotates shift a doubled copy so that bits leaving one end re-enter the other.
  assign dbl_r = {a_i, a_i} >> sh;
  assign dbl_l = {a_i, a_i} << sh;
  assign sra   = $signed(a_i) >>> sh;
  assign prod  = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign quot  = $signed(a_i) / $signed(b_i);
  assign rem   = $signed(a_i) % $signed(b_i);

  assign unused_bits = ^{dbl_r[63:32], dbl_l[31:0]};

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD:  result_o = {32'd0, a_i + b_i};
      OP_SUB:  result_o = {32'd0, a_i - b_i};
      OP_AND:  result_o = {32'd0, a_i & b_i};
      OP_OR:   result_o = {32'd0, a_i | b_i};
      OP_SHR:  result_o = {32'd0, a_i >> sh};
      OP_SHRA: result_o = {32'd0, sra};
      OP_SHL:  result_o = {32'd0, a_i << sh};
      OP_ROR:  result_o = {32'd0, dbl_r[31:0]};
      OP_ROL:  result_o = {32'd0, dbl_l[63:32]};
      OP_MUL:  result_o = prod;
      OP_DIV:  result_o = (b_i == 32'd0) ? 64'd0 : {rem, quot};
      OP_NEG:  result_o = {32'd0, 32'd0 - b_i};
      OP_NOT:  result_o = {32'd0, ~b_i};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/cpu_datapath.sv
// Single-bus CPU datapath: register file, PC/IR/MAR/MDR, Y/Z/HI/LO, CON
// flip-flop, 512-word memory and a priority bus multiplexer.
module cpu_datapath
  import cpu_datapath_pkg::*;
(
  input  logic        PCout,
  input  logic        Zlowout,
  input  logic        MDRout,
  input  logic        MARin,
  input  logic        Zin,
  input  logic        PCin,
  input  logic        MDRin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        IncPC,
  input  logic        Read,
  input  logic        Write,
  input  logic        AND,
  input  logic        Clock,
  input  logic        ZHighout,
  input  logic        LOout,
  input  logic        HIout,
  input  logic        Cout,
  input  logic        InPortout,
  input  logic        GRA,
  input  logic        GRB,
  input  logic        GRC,
  input  logic        Rin,
  input  logic        Rout,
  input  logic        BAout,
  input  logic [4:0]  operation,
  output logic [31:0] encoder_input,
  input  logic [15:0] Register_enable_Signals,
  input  logic        CON_in,
  input  logic        Clear,
  input  logic [31:0] InPort_in
);

  logic [31:0] r_q [NUM_REGS];
  logic [31:0] pc_q, ir_q, mar_q, mdr_q, y_q, hi_q, lo_q, inport_q;
  logic [63:0] z_q;
  logic        con_q;
  logic [31:0] mem_q [MEM_DEPTH];

  logic [3:0]  reg_field;
  logic [15:0] reg_sel;
  logic [15:0] reg_load;
  logic [31:0] bus;
  logic [31:0] c_ext;
  logic [31:0] mem_rd;
  logic [4:0]  alu_op;
  logic [63:0] alu_res;
  logic        muldiv;
  logic [31:0] pc_d, mdr_d;
  logic        con_d;
  logic        unused_bits;

  assign reg_field = ({4{GRA}} & ir_q[26:23]) | ({4{GRB}} & ir_q[22:19]) | ({4{GRC}} & ir_q[18:15]);
  assign reg_sel   = 16'b1 << reg_field;
  assign reg_load  = Register_enable_Signals | ({16{Rin}} & reg_sel);
  assign c_ext     = sext19(ir_q[18:0]);
  assign mem_rd    = mem_q[mar_q[MEM_AW-1:0]];

  assign encoder_input = {8'd0, Cout, InPortout, MDRout, PCout, Zlowout, ZHighout,
                          LOout, HIout, reg_sel & {16{Rout | BAout}}};

  // Later assignments win, so the highest-index active source owns the bus.
  always_comb begin
    bus = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (encoder_input[i]) bus = r_q[i];
    end
    if (encoder_input[0] && BAout) bus = '0;
    if (encoder_input[ENC_HI])     bus = hi_q;
    if (encoder_input[ENC_LO])     bus = lo_q;
    if (encoder_input[ENC_ZHIGH])  bus = z_q[63:32];
    if (encoder_input[ENC_ZLOW])   bus = z_q[31:0];
    if (encoder_input[ENC_PC])     bus = pc_q;
    if (encoder_input[ENC_MDR])    bus = mdr_q;
    if (encoder_input[ENC_INPORT]) bus = inport_q;
    if (encoder_input[ENC_C])      bus = c_ext;
  end

  assign alu_op = AND ? 5'(OP_AND) : operation;
  assign muldiv = (alu_op == 5'(OP_MUL)) || (alu_op == 5'(OP_DIV));

  cpu_alu u_alu (
    .a_i      (y_q),
    .b_i      (bus),
    .op_i     (alu_op),
    .result_o (alu_res)
  );

  assign pc_d  = IncPC ? pc_q + 32'd1 : bus;
  assign mdr_d = Read ? mem_rd : bus;

  always_comb begin
    con_d = 1'b0;
    case (ir_q[20:19])
      2'b00: con_d = (bus == 32'd0);
      2'b01: con_d = (bus != 32'd0);
      2'b10: con_d = ~bus[31];
      2'b11: con_d = bus[31];
      default: con_d = 1'b0;
    endcase
  end

  assign unused_bits = ^{mar_q[31:MEM_AW], ir_q[31:27]};

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      for (int i = 0; i < int'(NUM_REGS); i++) r_q[i] <= '0;
      pc_q     <= '0;
      ir_q     <= '0;
      mar_q    <= '0;
      mdr_q    <= '0;
      y_q      <= '0;
      z_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      inport_q <= '0;
      con_q    <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (reg_load[i]) r_q[i] <= bus;
      end
      if (PCin)   pc_q  <= pc_d;
      if (IRin)   ir_q  <= bus;
      if (MARin)  mar_q <= bus;
      if (MDRin)  mdr_q <= mdr_d;
      if (Yin)    y_q   <= bus;
      if (Zin)    z_q   <= alu_res;
      if (Zin && muldiv) begin
        hi_q <= alu_res[63:32];
        lo_q <= alu_res[31:0];
      end
      if (CON_in) con_q <= con_d;
      inport_q <= InPort_in;
    end
  end

  // Memory contents survive Clear.
  always_ff @(posedge Clock) begin
    if (Write) mem_q[mar_q[MEM_AW-1:0]] <= mdr_q;
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed instruction sequences plus
// randomized ALU traffic compared against an arithmetic reference model.
module tb_cpu_datapath;
  import cpu_datapath_pkg::*;

  logic        PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC;
  logic        Read, Write, AND, Clock, ZHighout, LOout, HIout, Cout, InPortout;
  logic        GRA, GRB, GRC, Rin, Rout, BAout, CON_in, Clear;
  logic [4:0]  operation;
  logic [31:0] encoder_input;
  logic [15:0] Register_enable_Signals;
  logic [31:0] InPort_in;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi, exp_lo;

  cpu_datapath dut (
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin), .Zin(Zin),
    .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .Read(Read),
    .Write(Write), .AND(AND), .Clock(Clock), .ZHighout(ZHighout), .LOout(LOout),
    .HIout(HIout), .Cout(Cout), .InPortout(InPortout), .GRA(GRA), .GRB(GRB), .GRC(GRC),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .operation(operation),
    .encoder_input(encoder_input), .Register_enable_Signals(Register_enable_Signals),
    .CON_in(CON_in), .Clear(Clear), .InPort_in(InPort_in)
  );

  // Clock / watchdog
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model
  function automatic logic [63:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned s;
    int q, r;
    longint p;
    s = b % 32;
    case (op)
      5'b00011: return {32'd0, a + b};
      5'b00100: return {32'd0, a - b};
      5'b00101: return {32'd0, a & b};
      5'b00110: return {32'd0, a | b};
      5'b00111: return {32'd0, a >> s};
      5'b01000: return {32'd0, 32'($signed(a) >>> s)};
      5'b01001: return {32'd0, a << s};
      5'b01010: return {32'd0, (s == 0) ? a : ((a >> s) | (a << (32 - s)))};
      5'b01011: return {32'd0, (s == 0) ? a : ((a << s) | (a >> (32 - s)))};
      5'b01111: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      5'b10000: begin
        if (b == 32'd0) return 64'd0;
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      5'b10001: return {32'd0, -b};
      5'b10010: return {32'd0, ~b};
      default:  return 64'd0;
    endcase
  endfunction

  function automatic logic con_ref(input logic [1:0] cond, input logic [31:0] v);
    case (cond)
      2'b00: return int'(v) == 0;
      2'b01: return int'(v) != 0;
      2'b10: return int'(v) >= 0;
      default: return int'(v) < 0;
    endcase
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic clear_ctrl();
    {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC} = '0;
    {Read, Write, AND, ZHighout, LOout, HIout, Cout, InPortout} = '0;
    {GRA, GRB, GRC, Rin, Rout, BAout, CON_in} = '0;
    operation = '0;
    Register_enable_Signals = '0;
  endtask

  // Puts val into the InPort register and raises InPortout; caller adds enables and ticks.
  task automatic inport_to_bus(input logic [31:0] val);
    clear_ctrl();
    InPort_in = val;
    tick();
    InPortout = 1'b1;
  endtask

  task automatic mem_write(input logic [31:0] addr, input logic [31:0] data);
    inport_to_bus(addr); MARin = 1'b1; tick();
    inport_to_bus(data); MDRin = 1'b1; tick();
    clear_ctrl(); Write = 1'b1; tick();
    clear_ctrl();
  endtask

  task automatic load_y(input logic [31:0] v);
    inport_to_bus(v); Yin = 1'b1; tick();
    clear_ctrl();
  endtask

  task automatic load_ir(input logic [31:0] v);
    inport_to_bus(v); IRin = 1'b1; tick();
    clear_ctrl();
  endtask

  task automatic alu_run(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                         input logic and_force, input string tag);
    logic [4:0]  eff;
    logic [63:0] exp_z;
    load_y(a);
    inport_to_bus(b);
    operation = op; AND = and_force; Zin = 1'b1;
    tick();
    clear_ctrl();
    eff = and_force ? 5'b00101 : op;
    exp_z = alu_ref(eff, a, b);
    if (eff == 5'b01111 || eff == 5'b10000) begin
      exp_hi = exp_z[63:32];
      exp_lo = exp_z[31:0];
    end
    check({tag, "_z"}, dut.z_q, exp_z);
    check({tag, "_hi"}, {32'd0, dut.hi_q}, {32'd0, exp_hi});
    check({tag, "_lo"}, {32'd0, dut.lo_q}, {32'd0, exp_lo});
  endtask

  initial begin
    logic [4:0]  ops [15];
    logic [31:0] a, b;
    logic [4:0]  op;
    logic [31:0] con_vals [8];
    logic [15:0] mask;

    ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
            5'b01010, 5'b01011, 5'b01111, 5'b10000, 5'b10001, 5'b10010, 5'b00000, 5'b11111};
    con_vals = '{32'd0, 32'd5, 32'h80000000, 32'hFFFFFFFF, 32'd1, 32'h7FFFFFFF, 32'hFFFFFFFB, 32'd0};

    clear_ctrl();
    InPort_in = 32'd0;
    Clear = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    repeat (2) @(posedge Clock);
    #1;
    check("rst_pc", {32'd0, dut.pc_q}, 64'd0);
    check("rst_ir", {32'd0, dut.ir_q}, 64'd0);
    check("rst_mdr", {32'd0, dut.mdr_q}, 64'd0);
    check("rst_z", dut.z_q, 64'd0);
    check("rst_r7", {32'd0, dut.r_q[7]}, 64'd0);
    check("rst_con", {63'd0, dut.con_q}, 64'd0);
    check("rst_enc", {32'd0, encoder_input}, 64'd0);
    check("rst_bus", {32'd0, dut.bus}, 64'd0);
    Clear = 1'b0;

    // Program memory through the datapath, then restart from a clean state.
    mem_write(32'd0, 32'h01000095);
    mem_write(32'h95, 32'h00001234);
    Clear = 1'b1; #2; Clear = 1'b0;
    check("clr_pulse_mar", {32'd0, dut.mar_q}, 64'd0);

    // ld R2, 0x95(R0)
    clear_ctrl(); PCout = 1'b1; MARin = 1'b1; tick();
    clear_ctrl(); PCin = 1'b1; IncPC = 1'b1; tick();
    clear_ctrl(); Read = 1'b1; MDRin = 1'b1; tick();
    clear_ctrl(); MDRout = 1'b1; IRin = 1'b1; tick();
    check("ld_ir", {32'd0, dut.ir_q}, 64'h01000095);
    clear_ctrl(); GRB = 1'b1; Rout = 1'b1; Yin = 1'b1; tick();
    clear_ctrl(); Cout = 1'b1; operation = 5'b00011; Zin = 1'b1; tick();
    check("ld_zlow", {32'd0, dut.z_q[31:0]}, 64'h95);
    clear_ctrl(); Zlowout = 1'b1; MARin = 1'b1; tick();
    clear_ctrl(); Read = 1'b1; MDRin = 1'b1; tick();
    clear_ctrl(); MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1; #1;
    check("ld_enc", {32'd0, encoder_input}, 64'h00200000);
    tick();
    clear_ctrl();
    check("ld_r2", {32'd0, dut.r_q[2]}, 64'h1234);
    check("ld_pc", {32'd0, dut.pc_q}, 64'd1);
    check("ld_mar", {32'd0, dut.mar_q}, 64'h95);

    // Two sources at once: the higher-index one wins.
    PCout = 1'b1; MDRout = 1'b1; #1;
    check("prio_enc", {32'd0, encoder_input}, 64'h00300000);
    check("prio_bus", {32'd0, dut.bus}, 64'h1234);
    clear_ctrl();

    // Multiple enables all capture the same bus value.
    mask = 16'hA5A1;
    inport_to_bus(32'hCAFE0001);
    Register_enable_Signals = mask; Yin = 1'b1; MARin = 1'b1;
    tick();
    clear_ctrl();
    for (int i = 0; i < 16; i++)
      check($sformatf("multi_r%0d", i), {32'd0, dut.r_q[i]},
            {32'd0, mask[i] ? 32'hCAFE0001 : ((i == 2) ? 32'h1234 : 32'd0)});
    check("multi_y", {32'd0, dut.y_q}, 64'hCAFE0001);

    // R0 as a base address reads as zero; as a plain register it drives its contents.
    load_ir(32'd0);
    GRA = 1'b1; BAout = 1'b1; #1;
    check("baout_r0_bus", {32'd0, dut.bus}, 64'd0);
    check("baout_r0_enc", {32'd0, encoder_input}, 64'h1);
    clear_ctrl(); GRA = 1'b1; Rout = 1'b1; #1;
    check("rout_r0_bus", {32'd0, dut.bus}, 64'hCAFE0001);
    clear_ctrl();

    // Directed ALU cases
    alu_run(32'd7, 32'd3, 5'b00100, 1'b0, "sub");
    alu_run(32'hFFFFFFFE, 32'd3, 5'b01111, 1'b0, "mul");
    check("mul_z_abs", dut.z_q, 64'hFFFFFFFF_FFFFFFFA);
    alu_run(32'd17, 32'd5, 5'b10000, 1'b0, "div");
    check("div_z_abs", dut.z_q, 64'h00000002_00000003);
    alu_run(32'd17, 32'd0, 5'b10000, 1'b0, "div0");
    alu_run(32'hF0F0F0F0, 32'hFF00FF00, 5'b00011, 1'b1, "and_force");
    alu_run(32'h80000001, 32'd0, 5'b01010, 1'b0, "ror0");

    // Randomized ALU traffic
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 14)];
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if (op == 5'b10000 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
      alu_run(a, b, op, 1'($urandom_range(0, 7) == 0), $sformatf("rnd%0d_op%0h", n, op));
    end

    // Condition flip-flop
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 2; k++) begin
        b = con_vals[c * 2 + k];
        load_ir(32'(c) << 19);
        inport_to_bus(b); CON_in = 1'b1; tick();
        clear_ctrl();
        check($sformatf("con_c%0d_%h", c, b), {63'd0, dut.con_q}, {63'd0, con_ref(2'(c), b)});
      end
    end

    // Clear mid-cycle zeroes state without waiting for a clock edge.
    load_y(32'h55AA55AA);
    @(negedge Clock);
    Clear = 1'b1;
    #1;
    check("mid_clr_r2", {32'd0, dut.r_q[2]}, 64'd0);
    check("mid_clr_y", {32'd0, dut.y_q}, 64'd0);
    check("mid_clr_z", dut.z_q, 64'd0);
    check("mid_clr_hi", {32'd0, dut.hi_q}, 64'd0);
    check("mid_clr_lo", {32'd0, dut.lo_q}, 64'd0);
    check("mid_clr_inport", {32'd0, dut.inport_q}, 64'd0);
    check("mid_clr_pc", {32'd0, dut.pc_q}, 64'd0);
    check("mid_clr_bus", {32'd0, dut.bus}, 64'd0);
    check("mid_clr_mem", {32'd0, dut.mem_q[9'h95]}, 64'h1234);
    @(posedge Clock);
    #1;
    Clear = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
